pwm_duty_ramp_ctrl: RTL and testbench
=====================================

// Module: pwm_duty_ramp_ctrl
// PURPOSE
//  Sequences the duty input of the PWM/dead-time datapath. Accepts duty-change
//  requests over a valid/ready handshake and ramps duty toward the target by a
//  programmable step, applied only at PWM period boundaries (glitch-free).
//  Latches an external fault and forces duty to 0 until explicitly cleared.
//  Sits between the control/register interface and the PWM generator's duty port.
// PARAMETERS
//  R          8  PWM resolution; duty is R+1 bits, legal range 0..2^R
//  STEP_BITS  4  width of ramp step per period
// PORTS
//  clk            in   1          system clock, all logic on rising edge
//  reset          in   1          asynchronous, active-high reset
//  enable         in   1          0 = controller off, duty forced to 0
//  period_end     in   1          1-cycle pulse from PWM counter wrap
//  req_valid      in   1          duty request valid
//  req_ready      out  1          controller can accept a request
//  req_duty       in   R+1        requested target duty
//  req_step       in   STEP_BITS  ramp step per period; 0 = jump
//  fault          in   1          level fault input (e.g. overcurrent)
//  fault_clr      in   1          clear request for latched fault
//  duty_out       out  R+1        registered duty to PWM datapath
//  busy           out  1          1 while ramping
//  done           out  1          1-cycle pulse when duty_out reaches target
//  fault_latched  out  1          sticky fault indication
// BEHAVIOUR
//  Reset: state IDLE; duty_out=0, target=0, busy=0, done=0, fault_latched=0.
//  States: IDLE, RAMP, FAULT. All outputs registered except
//   req_ready = (state==IDLE) & enable & ~fault_latched; busy = (state==RAMP).
//  Priority per cycle: reset > fault > ~enable > handshake/ramp.
//  IDLE: transfer on req_valid&req_ready; target<=min(req_duty,2^R),
//   step<=req_step; -> RAMP. No transfer -> duty_out holds.
//  RAMP: duty_out changes only on cycles with period_end=1:
//   step==0 -> duty_out<=target.
//   up: duty_out<=min(duty_out+step,target) (sum computed in R+2 bits).
//   down: duty_out<=max(duty_out-step,target) (no underflow past target).
//   The edge that makes duty_out==target pulses done and returns to IDLE.
//   target==duty_out at accept: done at first period_end, duty unchanged.
//  Handshake: req_ready=0 during RAMP; no retarget mid-ramp. Held req_valid
//   is accepted in the first IDLE cycle after done (earliest: 1 cycle later).
//  Accept and period_end in same cycle: accept only; first step at the NEXT
//   period_end (one-full-period alignment).
//  fault=1 at any edge: -> FAULT, duty_out<=0, fault_latched<=1, busy=0,
//   pending ramp discarded, done not pulsed.
//  FAULT: exits to IDLE (duty_out=0, target=0) only on an edge with
//   fault_clr=1 and fault=0; fault_clr while fault=1 is ignored.
//  enable=0 (no fault): -> IDLE, duty_out<=0, target<=0 on next edge,
//   in-progress ramp aborted without done.
//  Reset mid-ramp or mid-fault: immediate return to reset values.
//  period_end pulses wider than 1 cycle step once per high cycle (caller
//   guarantees 1-cycle pulses).
// TESTING
//  1 reset; req duty=100 step=10 -> duty_out 10,20..100 on 10 successive
//    period_end; done pulses with 100; req_ready=1 next cycle.
//  2 from 100, req duty=5 step=30 -> 70,40,10,5; done on 5; no underflow.
//  3 req duty=200 step=0 -> duty_out=200 at first period_end; req duty=300
//    (R=8) -> clamps, duty_out=256.
//  4 fault mid-ramp at duty 40 -> duty_out=0 next edge, fault_latched=1,
//    req_ready=0; fault_clr with fault=1 ignored; fault=0+fault_clr -> IDLE.
//  5 accept coincident with period_end -> duty_out unchanged that edge,
//    first step next period_end; req_valid held during RAMP not accepted.
//  6 reset asserted mid-ramp (async, off clock edge) -> all outputs 0
//    immediately; enable=0 mid-ramp -> duty_out=0, no done pulse.

Source files
------------

// File: rtl/pwm_duty_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_ramp_ctrl
// Description : Duty-cycle sequencer for the PWM datapath. Accepts duty
//               requests over valid/ready, ramps duty toward the target by a
//               programmable step at PWM period boundaries, and latches an
//               external fault that forces duty to zero until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_ramp_ctrl #(
  parameter int R         = 8,
  parameter int STEP_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 period_end,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [R:0]           req_duty,
  input  logic [STEP_BITS-1:0] req_step,
  input  logic                 fault,
  input  logic                 fault_clr,
  output logic [R:0]           duty_out,
  output logic                 busy,
  output logic                 done,
  output logic                 fault_latched
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Largest legal duty (100 %), 2^R in R+1 bits.
  localparam logic [R:0] DUTY_MAX = {1'b1, {R{1'b0}}};

  state_t               state_q, state_d;
  logic [R:0]           duty_q, duty_d;
  logic [R:0]           target_q, target_d;
  logic [STEP_BITS-1:0] step_q, step_d;
  logic                 fault_q, fault_d;
  logic                 done_q, done_d;

  logic [R+1:0] w_duty_ext;
  logic [R+1:0] w_target_ext;
  logic [R+1:0] w_step_ext;
  logic [R+1:0] w_sum_up;
  logic [R+1:0] w_tgt_plus_step;
  logic [R:0]   w_step_short;
  logic [R:0]   w_diff_down;
  logic [R:0]   w_req_clamped;

  // Ramp arithmetic carried one bit wider so that duty+step never wraps.
  assign w_duty_ext      = {1'b0, duty_q};
  assign w_target_ext    = {1'b0, target_q};
  assign w_step_ext      = (R+2)'(step_q);
  assign w_sum_up        = w_duty_ext + w_step_ext;
  assign w_tgt_plus_step = w_target_ext + w_step_ext;
  assign w_step_short    = (R+1)'(step_q);
  // Only used when duty exceeds target+step, so it can never underflow.
  assign w_diff_down     = duty_q - w_step_short;
  assign w_req_clamped   = (req_duty > DUTY_MAX) ? DUTY_MAX : req_duty;

  assign req_ready     = (state_q == ST_IDLE) && enable && !fault_q;
  assign busy          = (state_q == ST_RAMP);
  assign duty_out      = duty_q;
  assign done          = done_q;
  assign fault_latched = fault_q;

  // State and datapath registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      duty_q   <= '0;
      target_q <= '0;
      step_q   <= '0;
      fault_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      step_q   <= step_d;
      fault_q  <= fault_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: fault overrides disable, which overrides normal work.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    step_d   = step_q;
    fault_d  = fault_q;
    done_d   = 1'b0;

    if (fault) begin
      state_d  = ST_FAULT;
      duty_d   = '0;
      target_d = '0;
      fault_d  = 1'b1;
    end else if (state_q == ST_FAULT) begin
      // The latched fault survives a disable; only an explicit clear exits.
      if (fault_clr) begin
        state_d  = ST_IDLE;
        duty_d   = '0;
        target_d = '0;
        fault_d  = 1'b0;
      end
    end else if (!enable) begin
      state_d  = ST_IDLE;
      duty_d   = '0;
      target_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // A coincident period_end is ignored so the first step lands a
          // full period after acceptance.
          if (req_valid && req_ready) begin
            target_d = w_req_clamped;
            step_d   = req_step;
            state_d  = ST_RAMP;
          end
        end
        ST_RAMP: begin
          if (period_end) begin
            if ((step_q == '0) ||
                ((target_q >= duty_q) && (w_sum_up >= w_target_ext)) ||
                ((target_q <  duty_q) && (w_duty_ext <= w_tgt_plus_step))) begin
              duty_d  = target_q;
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else if (target_q >= duty_q) begin
              duty_d = w_sum_up[R:0];
            end else begin
              duty_d = w_diff_down;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_ramp_ctrl
// Description : Scoreboard bench for pwm_duty_ramp_ctrl. The driver pushes
//               the outputs expected after each clock edge; a monitor pops
//               and compares them shortly after that edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_ramp_ctrl;

  localparam int R         = 8;
  localparam int STEP_BITS = 5;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b0;
  logic                 period_end = 1'b0;
  logic                 req_valid = 1'b0;
  logic                 req_ready;
  logic [R:0]           req_duty = '0;
  logic [STEP_BITS-1:0] req_step = '0;
  logic                 fault = 1'b0;
  logic                 fault_clr = 1'b0;
  logic [R:0]           duty_out;
  logic                 busy;
  logic                 done;
  logic                 fault_latched;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string tag;
    int    duty;
    logic  done;
    logic  busy;
    logic  flt;
    logic  rdy;
  } exp_t;

  exp_t sb[$];

  pwm_duty_ramp_ctrl #(.R(R), .STEP_BITS(STEP_BITS)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .period_end    (period_end),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_duty      (req_duty),
    .req_step      (req_step),
    .fault         (fault),
    .fault_clr     (fault_clr),
    .duty_out      (duty_out),
    .busy          (busy),
    .done          (done),
    .fault_latched (fault_latched)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: compare the expectation queued for this edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check_val({e.tag, ".duty"},  32'(duty_out),      32'(e.duty));
      check_val({e.tag, ".done"},  32'(done),          32'(e.done));
      check_val({e.tag, ".busy"},  32'(busy),          32'(e.busy));
      check_val({e.tag, ".fault"}, 32'(fault_latched), 32'(e.flt));
      check_val({e.tag, ".ready"}, 32'(req_ready),     32'(e.rdy));
    end
  end

  // Drive one cycle of inputs (called just after a falling edge) and queue
  // the outputs expected after the next rising edge.
  task automatic drv(input logic en, input logic flt, input logic clr,
                     input logic pe, input logic rv, input int rd, input int rs,
                     input string tag, input int ed, input logic edn,
                     input logic eb, input logic efl, input logic erd);
    exp_t e;
    enable     = en;
    fault      = flt;
    fault_clr  = clr;
    period_end = pe;
    req_valid  = rv;
    req_duty   = (R+1)'(rd);
    req_step   = STEP_BITS'(rs);
    e.tag = tag; e.duty = ed; e.done = edn; e.busy = eb; e.flt = efl; e.rdy = erd;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Normal-operation cycle: enabled, no fault; ready expected whenever idle.
  task automatic run(input logic pe, input logic rv, input int rd, input int rs,
                     input string tag, input int ed, input logic edn, input logic eb);
    drv(1'b1, 1'b0, 1'b0, pe, rv, rd, rs, tag, ed, edn, eb, 1'b0, !eb);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    check_val("rst.duty",  32'(duty_out),      0);
    check_val("rst.done",  32'(done),          0);
    check_val("rst.busy",  32'(busy),          0);
    check_val("rst.fault", 32'(fault_latched), 0);
    @(negedge clk);
    reset = 1'b0;
    run(0, 0, 0, 0, "idle", 0, 0, 0);

    // 1: ramp up 0 -> 100 by 10
    run(0, 1, 100, 10, "t1.acc", 0, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      run(0, 0, 0, 0, "t1.hold", 10 * (k - 1), 0, 1);
      run(1, 0, 0, 0, "t1.step", 10 * k, (k == 10), (k < 10));
    end
    run(0, 0, 0, 0, "t1.after", 100, 0, 0);

    // 2: ramp down 100 -> 5 by 30, last step clamps at target
    run(0, 1, 5, 30, "t2.acc", 100, 0, 1);
    run(1, 0, 0, 0, "t2.s1", 70, 0, 1);
    run(1, 0, 0, 0, "t2.s2", 40, 0, 1);
    run(0, 0, 0, 0, "t2.hold", 40, 0, 1);
    run(1, 0, 0, 0, "t2.s3", 10, 0, 1);
    run(1, 0, 0, 0, "t2.s4", 5, 1, 0);
    run(1, 0, 0, 0, "t2.idle", 5, 0, 0);

    // 3: step 0 jumps; request above 2^R clamps to 256
    run(0, 1, 200, 0, "t3.acc", 5, 0, 1);
    run(1, 0, 0, 0, "t3.jump", 200, 1, 0);
    run(0, 1, 300, 0, "t3.acc2", 200, 0, 1);
    run(1, 0, 0, 0, "t3.clamp", 256, 1, 0);

    // 4: fault mid-ramp
    drv(0, 0, 0, 0, 0, 0, 0, "t4.dis", 0, 0, 0, 0, 0);
    run(0, 1, 100, 20, "t4.acc", 0, 0, 1);
    run(1, 0, 0, 0, "t4.s1", 20, 0, 1);
    run(1, 0, 0, 0, "t4.s2", 40, 0, 1);
    drv(1, 1, 0, 1, 0, 0, 0, "t4.flt", 0, 0, 0, 1, 0);
    drv(1, 1, 1, 0, 1, 50, 1, "t4.clrhi", 0, 0, 0, 1, 0);
    drv(1, 0, 0, 1, 1, 50, 1, "t4.lowno", 0, 0, 0, 1, 0);
    drv(1, 0, 1, 0, 0, 0, 0, "t4.clr", 0, 0, 0, 0, 1);
    run(1, 0, 0, 0, "t4.idle", 0, 0, 0);

    // 5: accept coincident with period_end; held valid ignored mid-ramp
    run(1, 1, 50, 10, "t5.acc", 0, 0, 1);
    run(0, 1, 200, 10, "t5.wait", 0, 0, 1);
    run(1, 1, 200, 10, "t5.s1", 10, 0, 1);
    run(1, 1, 200, 10, "t5.s2", 20, 0, 1);
    run(1, 1, 200, 10, "t5.s3", 30, 0, 1);
    run(1, 1, 200, 10, "t5.s4", 40, 0, 1);
    run(1, 1, 200, 10, "t5.s5", 50, 1, 0);
    run(0, 1, 200, 10, "t5.acc2", 50, 0, 1);
    run(1, 0, 0, 0, "t5.s6", 60, 0, 1);
    run(0, 0, 0, 0, "t5.hold", 60, 0, 1);

    // 6a: asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check_val("t6.rst.duty",  32'(duty_out),      0);
    check_val("t6.rst.busy",  32'(busy),          0);
    check_val("t6.rst.done",  32'(done),          0);
    check_val("t6.rst.fault", 32'(fault_latched), 0);
    @(negedge clk);
    reset = 1'b0;

    // 6b: enable dropped mid-ramp aborts without done
    run(0, 1, 100, 10, "t6.acc", 0, 0, 1);
    run(1, 0, 0, 0, "t6.s1", 10, 0, 1);
    run(1, 0, 0, 0, "t6.s2", 20, 0, 1);
    drv(0, 0, 0, 1, 0, 0, 0, "t6.dis", 0, 0, 0, 0, 0);
    run(1, 0, 0, 0, "t6.idle", 0, 0, 0);

    @(negedge clk);
    if (sb.size() != 0) check_val("sb.left", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
